// File: rtl/addr_ctrl_pkg.sv
// Shared types and constants for the address controller: source-select modes
// and the fixed PC step for halfword-sized instructions.
package addr_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_ALU_IR   = 2'd1,
    MODE_MEM      = 2'd2,
    MODE_ALU_DATA = 2'd3
  } mode_e;

  localparam logic [31:0] PC_INC = 32'd2;

  // Clears bit 0 so every access lands on a halfword boundary.
  function automatic logic [31:0] alignHalf(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/addr_range_chk.sv
// Flags a raw source address that is either misaligned or beyond the end of
// memory (MEM_DEPTH 16-bit words, i.e. MEM_DEPTH*2 bytes). Used only with ADDR_CHECK_EN.
module addr_range_chk #(
  parameter int MEM_DEPTH = 4096
) (
  input  logic [31:0] src_i,
  output logic        err_o
);

  // Widened by one bit so depths up to 2^31 words still compare correctly.
  localparam logic [32:0] BYTE_LIMIT = 33'(MEM_DEPTH) << 1;

  always_comb begin
    err_o = src_i[0] | ({1'b0, src_i} >= BYTE_LIMIT);
  end

endmodule

// File: rtl/addr_ctrl.sv
// Address controller: picks the memory byte address from PC/ALU/popped sources
// and computes the next PC. Define ADDR_CHECK_EN to add the sticky o_err flag.
module addr_ctrl
  import addr_ctrl_pkg::*;
#(
  parameter  int MEM_DEPTH  = 4096,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_mode,
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_alu_addr,
  input  logic [31:0]           i_mem_addr,
  output logic [31:0]           o_pc,
`ifdef ADDR_CHECK_EN
  output logic                  o_err,
`endif
  output logic [ADDR_WIDTH-1:0] o_addr
);

  mode_e       mode;
  logic [31:0] src;
  logic [31:0] alignedSrc;

  // Source mux and next-PC generation; reset forces both outputs to zero.
  always_comb begin
    mode       = mode_e'(i_mode);
    src        = i_pc;
    alignedSrc = 32'd0;
    o_pc       = 32'd0;
    o_addr     = '0;
    case (mode)
      MODE_NORMAL:   src = i_pc;
      MODE_ALU_IR,
      MODE_ALU_DATA: src = i_alu_addr;
      MODE_MEM:      src = i_mem_addr;
      default:       src = i_pc;
    endcase
    alignedSrc = alignHalf(src);
    if (!rst) begin
      o_addr = alignedSrc[ADDR_WIDTH-1:0];
      case (mode)
        MODE_NORMAL:   o_pc = i_pc + PC_INC;
        MODE_ALU_IR,
        MODE_MEM:      o_pc = alignedSrc + PC_INC;
        MODE_ALU_DATA: o_pc = i_pc;
        default:       o_pc = i_pc + PC_INC;
      endcase
    end
  end

`ifdef ADDR_CHECK_EN
  logic chkErr;
  logic err_q;
  logic err_d;

  addr_range_chk #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_range_chk (
    .src_i(src),
    .err_o(chkErr)
  );

  // Sticky error: once set it stays until reset, and reset beats a same-cycle error.
  always_comb begin
    err_d = err_q | chkErr;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign o_err = err_q;
`else
  // Without the checker there is no clocked logic and the low source bit is discarded.
  logic unusedBits;
  assign unusedBits = clk ^ src[0] ^ alignedSrc[0];
`endif

endmodule

// File: tb/tb_addr_ctrl.sv
// Directed self-checking bench for addr_ctrl at the default depth (13-bit byte address).
// Error-flag scenarios are exercised only when ADDR_CHECK_EN is defined.
module tb_addr_ctrl;
  import addr_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  i_mode;
  logic [31:0] i_pc;
  logic [31:0] i_alu_addr;
  logic [31:0] i_mem_addr;
  logic [31:0] o_pc;
  logic [12:0] o_addr;
`ifdef ADDR_CHECK_EN
  logic        o_err;
`endif

  int total = 0;
  int bad   = 0;

  addr_ctrl #(.MEM_DEPTH(4096)) dut (
    .clk(clk),
    .rst(rst),
    .i_mode(i_mode),
    .i_pc(i_pc),
    .i_alu_addr(i_alu_addr),
    .i_mem_addr(i_mem_addr),
    .o_pc(o_pc),
`ifdef ADDR_CHECK_EN
    .o_err(o_err),
`endif
    .o_addr(o_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [31:0] pcReg;
    @(negedge clk);
    rst = 1'b1; i_pc = 32'h1234; i_alu_addr = 32'h0456; i_mem_addr = 32'h0788;
    for (int m = 0; m < 4; m++) begin
      i_mode = 2'(m);
      #1;
      total++;
      if (o_pc !== 32'd0) begin bad++; $display("[TB] FAIL rst_pc mode=%0d got=%h want=0", m, o_pc); end
      total++;
      if (o_addr !== 13'd0) begin bad++; $display("[TB] FAIL rst_addr mode=%0d got=%h want=0", m, o_addr); end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; i_mode = MODE_NORMAL; pcReg = 32'd0; i_pc = pcReg;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (o_addr !== 13'(2 * k)) begin bad++; $display("[TB] FAIL loop_addr step=%0d got=%h want=%h", k, o_addr, 2 * k); end
      total++;
      if (o_pc !== 32'(2 * k + 2)) begin bad++; $display("[TB] FAIL loop_pc step=%0d got=%h want=%h", k, o_pc, 2 * k + 2); end
      @(posedge clk);
      pcReg = o_pc;
      @(negedge clk);
      i_pc = pcReg;
    end
  endtask

  task automatic test_normal();
    @(negedge clk);
    i_mode = MODE_NORMAL; i_pc = 32'd10;
    #1;
    total++;
    if (o_addr !== 13'd10) begin bad++; $display("[TB] FAIL normal_addr got=%h want=a", o_addr); end
    total++;
    if (o_pc !== 32'd12) begin bad++; $display("[TB] FAIL normal_pc got=%h want=c", o_pc); end
  endtask

  task automatic test_alu();
    @(negedge clk);
    i_mode = MODE_ALU_IR; i_alu_addr = 32'd20; i_pc = 32'd100;
    #1;
    total++;
    if (o_addr !== 13'd20) begin bad++; $display("[TB] FAIL alu_ir_addr got=%h want=14", o_addr); end
    total++;
    if (o_pc !== 32'd22) begin bad++; $display("[TB] FAIL alu_ir_pc got=%h want=16", o_pc); end
    @(negedge clk);
    i_mode = MODE_ALU_DATA; i_alu_addr = 32'd20; i_pc = 32'd14;
    #1;
    total++;
    if (o_addr !== 13'd20) begin bad++; $display("[TB] FAIL alu_data_addr got=%h want=14", o_addr); end
    total++;
    if (o_pc !== 32'd14) begin bad++; $display("[TB] FAIL alu_data_pc got=%h want=e", o_pc); end
  endtask

  task automatic test_mem();
    @(negedge clk);
    i_mode = MODE_MEM; i_mem_addr = 32'd5; i_pc = 32'd40;
    #1;
    total++;
    if (o_addr !== 13'd4) begin bad++; $display("[TB] FAIL mem_addr got=%h want=4", o_addr); end
    total++;
    if (o_pc !== 32'd6) begin bad++; $display("[TB] FAIL mem_pc got=%h want=6", o_pc); end
`ifdef ADDR_CHECK_EN
    total++;
    if (o_err !== 1'b0) begin bad++; $display("[TB] FAIL mem_err_early got=%b want=0", o_err); end
    @(posedge clk); #1;
    total++;
    if (o_err !== 1'b1) begin bad++; $display("[TB] FAIL mem_err_set got=%b want=1", o_err); end
    @(negedge clk);
    i_mode = MODE_NORMAL; i_pc = 32'd8;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_err !== 1'b1) begin bad++; $display("[TB] FAIL mem_err_sticky got=%b want=1", o_err); end
    @(negedge clk);
    rst = 1'b1; i_mode = MODE_MEM; i_mem_addr = 32'd7;
    @(posedge clk); #1;
    total++;
    if (o_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_beats_err got=%b want=0", o_err); end
    @(negedge clk);
    rst = 1'b0; i_mode = MODE_NORMAL; i_pc = 32'd0;
`endif
  endtask

  task automatic test_range();
    @(negedge clk);
    i_mode = MODE_ALU_IR; i_alu_addr = 32'h2002; i_pc = 32'd0;
    #1;
    total++;
    if (o_addr !== 13'h0002) begin bad++; $display("[TB] FAIL range_addr got=%h want=0002", o_addr); end
    total++;
    if (o_pc !== 32'h2004) begin bad++; $display("[TB] FAIL range_pc got=%h want=2004", o_pc); end
`ifdef ADDR_CHECK_EN
    @(posedge clk); #1;
    total++;
    if (o_err !== 1'b1) begin bad++; $display("[TB] FAIL range_err_set got=%b want=1", o_err); end
    @(negedge clk);
    rst = 1'b1; i_mode = MODE_NORMAL; i_pc = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (o_err !== 1'b0) begin bad++; $display("[TB] FAIL range_err_clr got=%b want=0", o_err); end
    i_mode = MODE_NORMAL; i_pc = 32'h1FFE;
    @(posedge clk); #1;
    total++;
    if (o_err !== 1'b0) begin bad++; $display("[TB] FAIL edge_ok_err got=%b want=0", o_err); end
`endif
  endtask

  task automatic test_wrap();
    @(negedge clk);
    i_mode = MODE_NORMAL; i_pc = 32'hFFFF_FFFE;
    #1;
    total++;
    if (o_pc !== 32'd0) begin bad++; $display("[TB] FAIL wrap_pc got=%h want=0", o_pc); end
    total++;
    if (o_addr !== 13'h1FFE) begin bad++; $display("[TB] FAIL wrap_addr got=%h want=1ffe", o_addr); end
  endtask

  // Mode changes every cycle with all three sources holding distinct values.
  task automatic test_back_to_back();
    logic [1:0]  modes [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [12:0] expAddr [4] = '{13'h0ABC, 13'h1234, 13'h0ABC, 13'h0100};
    logic [31:0] expPc [4] = '{32'h0000_0100, 32'h0003_1236, 32'h0000_0ABE, 32'h0000_0102};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_mode = modes[k]; i_pc = 32'h0000_0100; i_alu_addr = 32'h0000_0ABD; i_mem_addr = 32'h0003_1234;
      #1;
      total++;
      if (o_addr !== expAddr[k]) begin bad++; $display("[TB] FAIL b2b_addr step=%0d got=%h want=%h", k, o_addr, expAddr[k]); end
      total++;
      if (o_pc !== expPc[k]) begin bad++; $display("[TB] FAIL b2b_pc step=%0d got=%h want=%h", k, o_pc, expPc[k]); end
    end
  endtask

  initial begin
    rst = 1'b1; i_mode = MODE_NORMAL; i_pc = '0; i_alu_addr = '0; i_mem_addr = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_normal();
    test_alu();
    test_mem();
    test_range();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_ctrl.md
# addr_ctrl

Address controller for the processor's fetch/data path. Each cycle it selects the memory byte address from one of four sources: the program counter, an ALU-computed instruction target, an ALU-computed data address, or a popped return address. It also computes the next program counter. It sits between the PC register (external, owned by the core) and the unified 16-bit-word memory.

## Interface
- MEM_DEPTH, default 4096: memory depth in 16-bit words.
- ADDR_WIDTH (localparam): $clog2(MEM_DEPTH*2), the byte-address width. It is 13 at the default depth.
- clk  in  1: clock.
- rst  in  1: reset, synchronous, active-high.
- i_mode  in  2: address source. 0 NORMAL, 1 ALU_IR, 2 MEM, 3 ALU_DATA.
- i_pc  in  32: current PC (byte address).
- i_alu_addr  in  32: ALU result used as an address.
- i_mem_addr  in  32: address popped from the stack/memory.
- o_pc  out  32: next PC. The core registers it.
- o_addr  out  ADDR_WIDTH: memory byte address for this cycle.
- o_err  out  1: sticky address-error flag. Present only with ADDR_CHECK_EN.

## Operation
- Source selection (src):
  - NORMAL selects i_pc.
  - ALU_IR and ALU_DATA select i_alu_addr.
  - MEM selects i_mem_addr.
- Alignment: asrc = {src[31:1], 1'b0}. All accesses are halfword aligned.
- o_addr = asrc[ADDR_WIDTH-1:0]. Upper bits are dropped.
- o_pc by mode:
  - NORMAL: i_pc + 2 (sequential fetch).
  - ALU_IR: asrc + 2 (jump; the target is fetched now).
  - MEM: asrc + 2 (return; the popped target is fetched now).
  - ALU_DATA: i_pc, unchanged (data access stalls the fetch for one cycle).
- Arithmetic is 32-bit unsigned and wraps modulo 2^32. For example, 0xFFFFFFFE + 2 = 0.
- While rst = 1, o_pc = 0 and o_addr = 0, regardless of mode.

## Timing
- o_pc and o_addr are purely combinational from i_mode, i_pc, i_alu_addr, i_mem_addr and rst. There is zero latency.
- A mode change takes effect in the same cycle. The next PC is visible after the external register's next posedge.
- o_err is registered on posedge clk:
  - It is 0 after any cycle with rst = 1.
  - It sets 1 cycle after the offending input.
  - It holds until rst.
  - If rst and an error occur in the same cycle, rst wins.
- There is no handshake; a new selection is accepted every cycle.

## Configuration
- ADDR_CHECK_EN defined:
  - Error condition: src[0] = 1 (misaligned), or src >= MEM_DEPTH*2 (out of range).
  - When the condition is true and rst = 0, o_err sets on the next posedge.
  - o_addr/o_pc behaviour is unchanged (still aligned and truncated).
- ADDR_CHECK_EN undefined: the o_err port and its register are absent. There is no clocked logic, and clk/rst only gate the combinational reset force.

## Structure
- Package addr_ctrl_pkg holds:
  - The mode enum: MODE_NORMAL=0, MODE_ALU_IR=1, MODE_MEM=2, MODE_ALU_DATA=3.
  - The PC increment constant 2.
- Optional sub-module addr_range_chk (ADDR_CHECK_EN only): takes src and MEM_DEPTH, outputs the misaligned/out-of-range error.

## Test plan
- rst=1, any mode -> o_pc=0, o_addr=0. Release rst with pc looped back through an external register -> pc sequence 0,2,4,6…
- NORMAL, i_pc=10 -> o_addr=10, o_pc=12.
- ALU_IR, i_alu_addr=20 -> o_addr=20, o_pc=22. ALU_DATA, i_alu_addr=20, i_pc=14 -> o_addr=20, o_pc=14.
- MEM, i_mem_addr=5 -> o_addr=4, o_pc=6. With ADDR_CHECK_EN, o_err=1 after the next posedge and it stays 1 until rst.
- ALU_IR, i_alu_addr=0x2002 (default depth) -> o_addr=0x0002, o_pc=0x2004. With ADDR_CHECK_EN, o_err sets. Then rst for one cycle -> o_err=0.
- NORMAL, i_pc=0xFFFFFFFE -> o_pc=0 (wrap), o_addr=0x1FFE.
